// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter:
// FSM state encoding, frame fall counts, keyboard command bytes and a parity helper.
package ps2_host_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INHIBIT,
      ST_RTS,
      ST_SHIFT,
      ST_ACK,
      ST_WAIT_IDLE
   } tx_state_t;

   // Device clock falls in one host-to-device frame.
   localparam logic [3:0] FRAME_FALLS = 4'd11;
   // The fall on which the host releases data for the stop bit.
   localparam logic [3:0] STOP_FALL   = 4'd10;

   // Keyboard command bytes and the device acknowledge response.
   localparam logic [7:0] CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] CMD_ENABLE   = 8'hF4;
   localparam logic [7:0] CMD_RESET    = 8'hFF;
   localparam logic [7:0] RESP_ACK     = 8'hFA;

   // Odd parity bit: makes the total number of ones in data+parity odd.
   function automatic logic odd_parity(input logic [7:0] data);
      return ~^data;
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: 2-FF synchronizer followed by a FILTER_DEPTH-sample glitch filter.
// The filtered level only changes after FILTER_DEPTH identical samples, and a
// one-cycle oFall pulse marks each filtered 1->0 transition. Shared with the receiver.
module ps2_line_filter #(
   parameter int FILTER_DEPTH = 8
) (
   input  logic Clock,
   input  logic Reset,
   input  logic iLine,
   output logic oLevel,
   output logic oFall
);

   logic [1:0]              r_sync;
   logic [FILTER_DEPTH-1:0] r_hist;
   logic                    r_level;
   logic                    r_fall;
   logic                    w_all_high;
   logic                    w_all_low;

   if (FILTER_DEPTH < 2) begin : g_bad_depth
      $error("FILTER_DEPTH must be at least 2");
   end

   assign w_all_high = &r_hist;
   assign w_all_low  = ~|r_hist;

   // Synchronise the pad, shift samples into the history, switch level only on a unanimous history.
   always_ff @(posedge Clock) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values of the others, exactly like the flops it models.
      if (Reset) begin
         r_sync  <= 2'b11;
         r_hist  <= '1;
         r_level <= 1'b1;
         r_fall  <= 1'b0;
      end else begin
         r_sync <= {r_sync[0], iLine};
         r_hist <= {r_hist[FILTER_DEPTH-2:0], r_sync[1]};
         r_fall <= 1'b0;
         if (w_all_high) begin
            r_level <= 1'b1;
         end else if (w_all_low) begin
            r_level <= 1'b0;
            r_fall  <= r_level;
         end
      end
   end

   assign oLevel = r_level;
   assign oFall  = r_fall;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter (inhibit, request-to-send,
// start, 8 data bits LSB first, odd parity, stop, device ACK check).
// Pads are driven through active-high "pull low" enables for open-drain buffers.
// Optional watchdog: define PS2_TX_TIMEOUT_EN to abort when the device stops clocking.
module ps2_host_tx
   import ps2_host_tx_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int FILTER_DEPTH   = 8,
   parameter int TIMEOUT_CYCLES = 750000
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic [7:0] iData,
   input  logic       iSend,
   output logic       oBusy,
   output logic       oDone,
   output logic       oAckError,
   output logic       oTimeout,
   output logic       oRxInhibit,
   input  logic       iPs2Clk,
   input  logic       iPs2Data,
   output logic       oPs2ClkLow,
   output logic       oPs2DataLow
);

   localparam int               INH_W    = $clog2(INHIBIT_CYCLES);
   localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);

   if (INHIBIT_CYCLES < 2) begin : g_bad_inhibit
      $error("INHIBIT_CYCLES must be at least 2");
   end
   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
   end

   tx_state_t        r_state;
   tx_state_t        w_next_state;
   logic [INH_W-1:0] r_inh_cnt;
   logic [8:0]       r_shift;      // {parity, data}, shifted out LSB first, refilled with 1s
   logic [3:0]       r_falls;
   logic             r_data_low;
   logic             r_ack_error;
   logic             r_done;
   logic             w_clk_level;
   logic             w_clk_fall;
   logic             w_data_level;
   logic             w_data_fall_unused;
   logic             w_accept;
   logic             w_sample_ack;
   logic             w_finish;
   logic             w_in_frame;
   logic             w_inh_last;
   logic             w_wdog_expired;

   ps2_line_filter #(.FILTER_DEPTH(FILTER_DEPTH)) u_clk_filter (
      .Clock  (Clock),
      .Reset  (Reset),
      .iLine  (iPs2Clk),
      .oLevel (w_clk_level),
      .oFall  (w_clk_fall)
   );

   ps2_line_filter #(.FILTER_DEPTH(FILTER_DEPTH)) u_data_filter (
      .Clock  (Clock),
      .Reset  (Reset),
      .iLine  (iPs2Data),
      .oLevel (w_data_level),
      .oFall  (w_data_fall_unused)
   );

   // States in which the host is waiting for device clock falls.
   assign w_in_frame = (r_state == ST_RTS) || (r_state == ST_SHIFT) || (r_state == ST_ACK);
   assign w_inh_last = (r_state == ST_INHIBIT) && (r_inh_cnt == INH_LAST);

   // FSM state register.
   always_ff @(posedge Clock) begin
      if (Reset) r_state <= ST_IDLE;
      else       r_state <= w_next_state;
   end

   // Next-state logic and pad/status outputs decoded from registered state.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can
      // leave it holding its previous value and infer a latch.
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_sample_ack = 1'b0;
      w_finish     = 1'b0;
      oBusy        = (r_state != ST_IDLE);
      oRxInhibit   = (r_state != ST_IDLE);
      oPs2ClkLow   = 1'b0;
      oPs2DataLow  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (iSend) begin
               w_accept     = 1'b1;
               w_next_state = ST_INHIBIT;
            end
         end
         ST_INHIBIT: begin
            oPs2ClkLow  = 1'b1;
            oPs2DataLow = w_inh_last;   // start bit goes out on the last inhibit cycle
            if (w_inh_last) w_next_state = ST_RTS;
         end
         ST_RTS: begin
            oPs2DataLow = 1'b1;
            if (w_clk_fall) w_next_state = ST_SHIFT;
         end
         ST_SHIFT: begin
            oPs2DataLow = r_data_low;
            if (w_clk_fall && (r_falls == STOP_FALL - 4'd1)) w_next_state = ST_ACK;
         end
         ST_ACK: begin
            if (w_clk_fall && (r_falls == FRAME_FALLS - 4'd1)) begin
               w_sample_ack = 1'b1;
               w_next_state = ST_WAIT_IDLE;
            end
         end
         ST_WAIT_IDLE: begin
            if (w_clk_level && w_data_level) begin
               w_finish     = 1'b1;
               w_next_state = ST_IDLE;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
      if (w_wdog_expired) w_next_state = ST_IDLE;
   end

   // Byte latch, bit serialiser, fall counter, inhibit timer and completion status.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_inh_cnt   <= '0;
         r_shift     <= '1;
         r_falls     <= '0;
         r_data_low  <= 1'b0;
         r_ack_error <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done    <= w_finish || w_wdog_expired;
         r_inh_cnt <= ((r_state == ST_INHIBIT) && !w_inh_last) ? r_inh_cnt + 1'b1 : '0;
         if (w_accept) begin
            r_shift    <= {odd_parity(iData), iData};
            r_falls    <= '0;
            r_data_low <= 1'b0;
         end else if (w_in_frame && w_clk_fall) begin
            // After parity has gone out the register holds only 1s, so fall 10 releases data.
            r_shift    <= {1'b1, r_shift[8:1]};
            r_data_low <= ~r_shift[0];
            r_falls    <= r_falls + 1'b1;
         end
         if (w_accept)            r_ack_error <= 1'b0;
         else if (w_sample_ack)   r_ack_error <= w_data_level;
         else if (w_wdog_expired) r_ack_error <= 1'b1;
      end
   end

`ifdef PS2_TX_TIMEOUT_EN
   localparam int              TO_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   logic [TO_W-1:0] r_wdog;
   logic            r_timeout;

   // Watchdog on device clock activity; restarts on entering RTS and on every fall.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_wdog    <= '0;
         r_timeout <= 1'b0;
      end else begin
         if (!w_in_frame || w_clk_fall) r_wdog <= '0;
         else                           r_wdog <= r_wdog + 1'b1;
         if (w_accept)            r_timeout <= 1'b0;
         else if (w_wdog_expired) r_timeout <= 1'b1;
      end
   end

   assign w_wdog_expired = w_in_frame && !w_clk_fall && (r_wdog == TO_LAST);
   assign oTimeout       = r_timeout;
`else
   assign w_wdog_expired = 1'b0;
   assign oTimeout       = 1'b0;
`endif

   assign oDone     = r_done;
   assign oAckError = r_ack_error;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with an open-drain PS/2 device model.
// The model clocks the frame, captures start/data/parity/stop bits on its rising
// clock edges and optionally drives the ACK. Define PS2_TX_TIMEOUT_EN to check the watchdog.
module tb_ps2_host_tx;
   import ps2_host_tx_pkg::*;

   localparam int HALF    = 40;     // device clock half period in system clocks
   localparam int INHIBIT = 5000;

   logic       Clock = 1'b0;
   logic       Reset = 1'b1;
   logic [7:0] iData = 8'h00;
   logic       iSend = 1'b0;
   logic       oBusy, oDone, oAckError, oTimeout, oRxInhibit;
   logic       oPs2ClkLow, oPs2DataLow;
   logic       dev_clk_low  = 1'b0;
   logic       dev_data_low = 1'b0;
   logic       w_ps2_clk, w_ps2_data;
   logic       prev_clk_low = 1'b0;

   int n_checks = 0;
   int n_errors = 0;
   int n_frames = 0;
   int n_dones  = 0;

   // Open-drain bus: either side pulling low wins.
   assign w_ps2_clk  = ~(oPs2ClkLow | dev_clk_low);
   assign w_ps2_data = ~(oPs2DataLow | dev_data_low);

   ps2_host_tx #(
      .INHIBIT_CYCLES (INHIBIT),
      .FILTER_DEPTH   (8),
      .TIMEOUT_CYCLES (1000)
   ) dut (
      .Clock       (Clock),
      .Reset       (Reset),
      .iData       (iData),
      .iSend       (iSend),
      .oBusy       (oBusy),
      .oDone       (oDone),
      .oAckError   (oAckError),
      .oTimeout    (oTimeout),
      .oRxInhibit  (oRxInhibit),
      .iPs2Clk     (w_ps2_clk),
      .iPs2Data    (w_ps2_data),
      .oPs2ClkLow  (oPs2ClkLow),
      .oPs2DataLow (oPs2DataLow)
   );

   always #10 Clock = ~Clock;

   // Count frame starts (inhibit assertions) and completion pulses.
   always @(negedge Clock) begin
      if (oPs2ClkLow && !prev_clk_low) n_frames++;
      if (oDone) n_dones++;
      prev_clk_low <= oPs2ClkLow;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, got %0d checks", n_checks);
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic send_byte(input logic [7:0] data);
      iData = data;
      iSend = 1'b1;
      @(negedge Clock);
      iSend = 1'b0;
   endtask

   // Device side of one frame. bits: [0] start, [8:1] data, [9] parity, [10] stop.
   // With n_falls < 11 the model stops after that fall and leaves the clock held low.
   task automatic device_frame(input int n_falls, input bit give_ack,
                               output int inh, output int ovl,
                               output logic [10:0] bits, output bit ok);
      int guard;
      inh = 0; ovl = 0; bits = '1; ok = 1'b1; guard = 0;
      while (!oPs2ClkLow && guard < 50) begin
         @(negedge Clock);
         guard++;
      end
      while (oPs2ClkLow && inh < 2 * INHIBIT) begin
         inh++;
         if (oPs2DataLow) ovl++;
         @(negedge Clock);
      end
      bits[0] = w_ps2_data;
      repeat (HALF) @(negedge Clock);
      for (int k = 1; k <= n_falls; k++) begin
         dev_clk_low = 1'b1;
         if (k == n_falls && n_falls < 11) begin
            repeat (30) @(negedge Clock);
            return;
         end
         repeat (HALF) @(negedge Clock);
         if (oPs2ClkLow) ok = 1'b0;
         dev_clk_low = 1'b0;
         if (k <= 10) bits[k] = w_ps2_data;
         if (k == 11) begin
            dev_data_low = 1'b0;
            return;
         end
         if (k == 10 && give_ack) begin
            repeat (HALF / 2) @(negedge Clock);
            dev_data_low = 1'b1;
            repeat (HALF - HALF / 2) @(negedge Clock);
         end else begin
            repeat (HALF) @(negedge Clock);
         end
      end
   endtask

   task automatic wait_done(input int limit, output bit seen);
      int cyc;
      cyc = 0; seen = 1'b0;
      while (cyc < limit) begin
         @(negedge Clock);
         if (oDone) begin
            seen = 1'b1;
            break;
         end
         cyc++;
      end
   endtask

   task automatic run_frame(input logic [7:0] data, input logic exp_parity, input bit give_ack);
      int          inh, ovl;
      logic [10:0] bits;
      bit          ok, seen;
      string       p;
      p = $sformatf("%02h", data);
      send_byte(data);
      check({p, "_busy_after_accept"}, oBusy, 1);
      device_frame(11, give_ack, inh, ovl, bits, ok);
      check({p, "_inhibit_cycles"}, inh, INHIBIT);
      check({p, "_start_on_last_inhibit"}, ovl, 1);
      check({p, "_host_clk_released"}, ok, 1);
      check({p, "_start_bit"}, bits[0], 0);
      check({p, "_data_byte"}, bits[8:1], data);
      check({p, "_parity_bit"}, bits[9], exp_parity);
      check({p, "_stop_bit"}, bits[10], 1);
      wait_done(300, seen);
      check({p, "_done_seen"}, seen, 1);
      check({p, "_ack_error"}, oAckError, give_ack ? 0 : 1);
      check({p, "_timeout_flag"}, oTimeout, 0);
      check({p, "_busy_at_done"}, oBusy, 0);
      check({p, "_rxinh_at_done"}, oRxInhibit, 0);
   endtask

   initial begin
      int          inh, ovl, n, done_before;
      logic [10:0] bits;
      bit          ok;

      // Reset state
      repeat (5) @(negedge Clock);
      check("reset_outputs",
            {oBusy, oDone, oAckError, oTimeout, oRxInhibit, oPs2ClkLow, oPs2DataLow}, 7'b0);
      Reset = 1'b0;
      repeat (5) @(negedge Clock);

      // 0xED with a stray send request in the middle of its frame
      fork
         run_frame(CMD_SET_LEDS, 1'b1, 1'b1);
         begin
            repeat (5300) @(negedge Clock);
            iData = 8'h00;
            iSend = 1'b1;
            @(negedge Clock);
            iSend = 1'b0;
         end
      join
      repeat (50) @(negedge Clock);
      check("ed_single_frame", n_frames, 1);
      check("ed_idle_after", oBusy, 0);

      // Parity boundaries
      run_frame(8'h00, 1'b1, 1'b1);
      run_frame(8'h01, 1'b0, 1'b1);

      // Device withholds ACK
      run_frame(8'h5A, 1'b1, 1'b0);

      // Reset during bit 4 of 0xFF
      send_byte(CMD_RESET);
      device_frame(5, 1'b1, inh, ovl, bits, ok);
      check("ff_busy_before_reset", oBusy, 1);
      done_before = n_dones;
      Reset = 1'b1;
      @(negedge Clock);
      Reset = 1'b0;
      check("rst_clk_released", oPs2ClkLow, 0);
      check("rst_data_released", oPs2DataLow, 0);
      check("rst_busy", oBusy, 0);
      check("rst_done", oDone, 0);
      dev_clk_low = 1'b0;
      repeat (200) @(negedge Clock);
      check("rst_no_done_pulse", n_dones - done_before, 0);
      check("rst_stays_idle", oBusy, 0);

      // Clean transfer after the aborted one
      run_frame(CMD_ENABLE, 1'b0, 1'b1);

      // Device never clocks
      send_byte(CMD_SET_LEDS);
      n = 0;
      while (oPs2ClkLow && n < 2 * INHIBIT) begin
         @(negedge Clock);
         n++;
      end
      n = 0;
      while (!oDone && n < 3000) begin
         n++;
         @(negedge Clock);
      end
`ifdef PS2_TX_TIMEOUT_EN
      check("to_rts_cycles", n, 1000);
      check("to_done", oDone, 1);
      check("to_timeout_flag", oTimeout, 1);
      check("to_ack_error", oAckError, 1);
      check("to_lines_released", {oPs2ClkLow, oPs2DataLow}, 2'b00);
      check("to_busy", oBusy, 0);
`else
      check("noto_no_done", n, 3000);
      check("noto_busy", oBusy, 1);
      check("noto_rts_data_low", oPs2DataLow, 1);
      check("noto_timeout_flag", oTimeout, 0);
      Reset = 1'b1;
      @(negedge Clock);
      Reset = 1'b0;
      check("noto_reset_idle", oBusy, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
